mult_seq_unit: RTL
==================

MULT_SEQ_UNIT -- requirements
Module: mult_seq_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameter WIDTH, default 32, operand width; all values below assume WIDTH=32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 a  input  32  multiplicand (busA side).
REQ-006 b  input  32  multiplier (busB side).
REQ-007 doMult  input  1  request level from execute; held high until mult_done is seen.
REQ-008 is_signed  input  1  1 = two's-complement multiply, 0 = unsigned.
REQ-009 busy  output  1  high while the multiply is iterating (RUN).
REQ-010 mult_done  output  1  result-valid acknowledge (4-phase handshake).
REQ-011 out  output  32  product bits [31:0].
REQ-012 out_hi  output  32  product bits [63:32].

Function
REQ-013 States SHALL be IDLE, RUN and DONE, with a 6-bit step counter.
REQ-014 IDLE: on an edge with doMult=1, the block captures a, b and is_signed, sets counter=0 and enters RUN; this edge is E0.
REQ-015 Signed capture: the block stores |a| and |b| as 32-bit unsigned values and sets neg = a[31]^b[31]. For 0x80000000 the magnitude is 0x80000000.
REQ-016 Unsigned capture: the block stores a and b unchanged and sets neg=0.
REQ-017 RUN: one shift-add step per edge into a 64-bit accumulator (if the multiplier LSB=1, add the multiplicand at the current weight), then increment the counter.
REQ-018 RUN SHALL take exactly 32 steps, at edges E1..E32.
REQ-019 At E32 the block SHALL:
  - load out/out_hi with the 64-bit product, two's-complement negated when neg=1;
  - set mult_done=1;
  - enter DONE.
REQ-020 Latency: mult_done is first high in the cycle following E32, i.e. 32 clocks after acceptance.
REQ-021 DONE: mult_done SHALL stay 1 and out/out_hi SHALL stay stable while doMult=1.
REQ-022 DONE exit: on the first edge with doMult=0, mult_done goes to 0 and the state returns to IDLE. out/out_hi keep the last product.
REQ-023 A doMult held high in DONE SHALL NOT start a new operation; a new start needs doMult low for at least one edge in IDLE.
REQ-024 Changes to a, b or is_signed during RUN or DONE SHALL be ignored.
REQ-025 doMult dropping during RUN SHALL NOT abort the operation. The block completes, enters DONE, and, if doMult is already 0, exits to IDLE on the next edge (mult_done high for exactly one cycle).
REQ-026 busy SHALL be 1 exactly in RUN: the cycles after E0 through E32.
REQ-027 The product SHALL be exact modulo 2^64 for all operand pairs in both modes; no overflow flag.

Reset
REQ-028 reset=1 at any edge SHALL force:
  - state IDLE, counter 0;
  - busy=0, mult_done=0;
  - out=0, out_hi=0;
  - accumulator and operand registers 0.
REQ-029 reset SHALL take priority over doMult on the same edge.
REQ-030 Reset asserted mid-RUN or mid-DONE SHALL discard the operation. After reset deasserts, a doMult=1 edge starts a fresh operation with full 32-cycle latency.

Verification
REQ-031 Unsigned 3 x 5, doMult held -> mult_done rises 32 cycles after E0; out=0x0000000F, out_hi=0; busy high 32 cycles.
REQ-032 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> out=0x00000001, out_hi=0xFFFFFFFE.
REQ-033 Signed cases:
  - -3 x 7 (0xFFFFFFFD, 0x00000007) -> out=0xFFFFFFEB, out_hi=0xFFFFFFFF;
  - -1 x -1 -> out=0x00000001, out_hi=0;
  - 0x80000000 x 0x80000000 -> out=0, out_hi=0x40000000.
REQ-034 Handshake:
  - doMult held high 10 cycles into DONE -> mult_done high all 10 cycles, no restart;
  - doMult low one edge -> mult_done=0, IDLE;
  - doMult high again -> new result after 32 cycles.
REQ-035 Reset at E10 of a signed 7 x 9 -> next cycle busy=0, mult_done=0, out=out_hi=0. A following unsigned 2 x 4 -> out=8 after 32 cycles.
REQ-036 Operands changed to 0 at E5 of 6 x 6 -> out=36, out_hi=0.

Source files
------------

// File: rtl/mult_seq_unit_if.sv
// mult_seq_unit_if: request/result bundle between execute stage and the sequential multiplier.
interface mult_seq_unit_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             doMult;
    logic             is_signed;
    logic             busy;
    logic             mult_done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    modport master(output a, b, doMult, is_signed, input busy, mult_done, out, out_hi);
    modport slave(input a, b, doMult, is_signed, output busy, mult_done, out, out_hi);
endinterface

// File: rtl/mult_seq_unit.sv
// mult_seq_unit: 32-step shift-add multiplier on magnitudes with sign fix-up
// and a 4-phase doMult/mult_done handshake.
module mult_seq_unit #(parameter int WIDTH = 32) (
    input logic          clk,
    input logic          reset,
    mult_seq_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [2*WIDTH-1:0] acc, acc_nx, mcand, mcand_nx, res, res_nx, sum;
    logic [WIDTH-1:0]   mplier, mplier_nx, mag_a, mag_b;
    logic               neg, neg_nx;
    assign mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign sum   = acc + (mplier[0] ? mcand : '0);
    assign bus.busy      = state == RUN;
    assign bus.mult_done = state == DONE;
    assign bus.out       = res[WIDTH-1:0];
    assign bus.out_hi    = res[2*WIDTH-1:WIDTH];
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            res    <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            neg    <= neg_nx;
            res    <= res_nx;
        end
    end
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        neg_nx    = neg;
        res_nx    = res;
        case (state)
            IDLE: if (bus.doMult) begin
                state_nx  = RUN;
                cnt_nx    = '0;
                acc_nx    = '0;
                mcand_nx  = {{WIDTH{1'b0}}, mag_a};
                mplier_nx = mag_b;
                neg_nx    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end
            RUN: begin
                acc_nx    = sum;
                mcand_nx  = mcand << 1;
                mplier_nx = mplier >> 1;
                cnt_nx    = cnt + 1'b1;
                // last step: the final partial sum goes straight to the result with sign applied
                if (cnt == CW'(WIDTH - 1)) begin
                    res_nx   = neg ? -sum : sum;
                    state_nx = DONE;
                end
            end
            DONE: state_nx = bus.doMult ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule
